// File: rtl/pio_bidir_irq.sv
// Avalon-MM bidirectional PIO: per-bit direction, atomic set/clear of outputs,
// synchronised edge capture with a maskable level interrupt.
module pio_bidir_irq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] OUT_RESET   = '0,
    parameter logic [31:0] DIR_RESET   = '0,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] oe_port,
    output logic                  irq
);

    localparam int unsigned W          = DATA_WIDTH;
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [W-1:0]                  data_out_q, data_out_d;
    logic [W-1:0]                  dir_q, dir_d;
    logic [W-1:0]                  mask_q, mask_d;
    logic [W-1:0]                  cap_q, cap_d;
    logic                          irq_q, irq_d;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  prev_q, prev_d;
    logic [ARM_W-1:0]              arm_q, arm_d;

    logic         wr;
    logic [W-1:0] wdata;
    logic [W-1:0] in_sync;
    logic [W-1:0] edge_raw;
    logic [W-1:0] det;
    logic [W-1:0] clr;
    logic [W-1:0] rd_word;

    assign wr      = chipselect & ~write_n;
    assign wdata   = writedata[W-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];

    // Next-state: synchroniser, arm window, edge capture, irq and register writes
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        mask_d     = mask_q;
        cap_d      = cap_q;
        irq_d      = irq_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], in_port};
        prev_d     = in_sync;
        arm_d      = arm_q;
        edge_raw   = '0;
        det        = '0;
        clr        = '0;

        if (arm_q != ARM_DONE) begin
            arm_d = arm_q + ARM_W'(1);
        end

        if (EDGE_TYPE == 0) begin
            edge_raw = in_sync & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_raw = ~in_sync & prev_q;
        end else begin
            edge_raw = in_sync ^ prev_q;
        end

        // Zero-initialised chain would fake edges on pins idling high
        if (arm_q == ARM_DONE) begin
            det = edge_raw;
        end

        if (wr && (address == ADDR_EDGE)) begin
            clr = wdata;
        end
        cap_d = (cap_q & ~clr) | det;
        irq_d = |(cap_q & mask_q);

        if (wr) begin
            case (address)
                ADDR_DATA:   data_out_d = wdata;
                ADDR_DIR:    dir_d      = wdata;
                ADDR_MASK:   mask_d     = wdata;
                ADDR_OUTSET: data_out_d = data_out_q | wdata;
                ADDR_OUTCLR: data_out_d = data_out_q & ~wdata;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= OUT_RESET[W-1:0];
            dir_q      <= DIR_RESET[W-1:0];
            mask_q     <= '0;
            cap_q      <= '0;
            irq_q      <= 1'b0;
            sync_q     <= '0;
            prev_q     <= '0;
            arm_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            irq_q      <= irq_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            arm_q      <= arm_d;
        end
    end

    // Zero-wait-state readback
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word = (dir_q & data_out_q) | (~dir_q & in_sync);
            ADDR_DIR:  rd_word = dir_q;
            ADDR_MASK: rd_word = mask_q;
            ADDR_EDGE: rd_word = cap_q;
            default:   rd_word = '0;
        endcase
        readdata = 32'(rd_word);
    end

    assign out_port = data_out_q;
    assign oe_port  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Scoreboard bench for pio_bidir_irq: two instances (32-bit rising/2-stage and
// 8-bit any-edge/3-stage), directed cases plus random traffic against a history model.
module tb_pio_bidir_irq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        cs  [2];
    logic        wn  [2];
    logic [2:0]  adr [2];
    logic [31:0] wd  [2];
    logic [31:0] pin [2];

    logic [31:0] rdata0, rdata1, out0, oe0;
    logic [7:0]  out1, oe1;
    logic        irq0, irq1;

    pio_bidir_irq #(
        .DATA_WIDTH(32), .OUT_RESET(32'h0), .DIR_RESET(32'h0),
        .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(adr[0]), .chipselect(cs[0]),
        .write_n(wn[0]), .writedata(wd[0]), .readdata(rdata0),
        .in_port(pin[0]), .out_port(out0), .oe_port(oe0), .irq(irq0)
    );

    pio_bidir_irq #(
        .DATA_WIDTH(8), .OUT_RESET(32'h3C), .DIR_RESET(32'h0F),
        .EDGE_TYPE(2), .SYNC_STAGES(3)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .address(adr[1]), .chipselect(cs[1]),
        .write_n(wn[1]), .writedata(wd[1]), .readdata(rdata1),
        .in_port(pin[1][7:0]), .out_port(out1), .oe_port(oe1), .irq(irq1)
    );

    typedef struct {
        int          d;
        int          sel;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t sbq[$];
    int    obs_n = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    // Reference model: pin history, register images, capture flags
    logic [31:0] m_out [2], m_dir [2], m_mask [2], m_cap [2];
    logic        m_irq [2];
    logic [31:0] samp  [2][8];
    int          since [2];

    function automatic int s_of(int d);         return (d == 0) ? 2 : 3; endfunction
    function automatic int e_of(int d);         return (d == 0) ? 0 : 2; endfunction
    function automatic logic [31:0] mk(int d);  return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF; endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_out[d]  = (d == 0) ? 32'h0 : 32'h3C;
            m_dir[d]  = (d == 0) ? 32'h0 : 32'h0F;
            m_mask[d] = '0;
            m_cap[d]  = '0;
            m_irq[d]  = 1'b0;
            since[d]  = 0;
            for (int k = 0; k < 8; k++) samp[d][k] = '0;
        end
    endtask

    task automatic model_step(int d);
        logic [31:0] cur, old, det, v, clr;
        logic        wrt, nirq;
        cur = samp[d][s_of(d)-1];
        old = samp[d][s_of(d)];
        case (e_of(d))
            0:       det = cur & ~old;
            1:       det = ~cur & old;
            default: det = cur ^ old;
        endcase
        det &= mk(d);
        if (since[d] < s_of(d) + 1) det = '0;
        wrt  = cs[d] && !wn[d];
        v    = wd[d] & mk(d);
        clr  = (wrt && adr[d] == 3'd3) ? v : 32'h0;
        nirq = |(m_cap[d] & m_mask[d]);
        m_cap[d] = (m_cap[d] & ~clr) | det;
        if (wrt) begin
            case (adr[d])
                3'd0: m_out[d]  = v;
                3'd1: m_dir[d]  = v;
                3'd2: m_mask[d] = v;
                3'd4: m_out[d]  = m_out[d] | v;
                3'd5: m_out[d]  = m_out[d] & ~v;
                default: ;
            endcase
        end
        m_irq[d] = nirq;
        for (int k = 7; k > 0; k--) samp[d][k] = samp[d][k-1];
        samp[d][0] = pin[d] & mk(d);
        if (since[d] < 100) since[d]++;
    endtask

    function automatic logic [31:0] model_read(int d, logic [2:0] a);
        case (a)
            3'd0:    return ((m_dir[d] & m_out[d]) | (~m_dir[d] & samp[d][s_of(d)-1])) & mk(d);
            3'd1:    return m_dir[d];
            3'd2:    return m_mask[d];
            3'd3:    return m_cap[d];
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else for (int d = 0; d < 2; d++) model_step(d);
    end

    // Monitor: pops one item per active read, then obs_n observation items
    function automatic logic [31:0] actual(item_t it);
        case (it.sel)
            0:       return (it.d == 0) ? rdata0 : rdata1;
            1:       return (it.d == 0) ? out0 : {24'h0, out1};
            2:       return (it.d == 0) ? oe0  : {24'h0, oe1};
            default: return {31'h0, (it.d == 0) ? irq0 : irq1};
        endcase
    endfunction

    task automatic pop_cmp(bit is_rd, int d);
        item_t       it;
        logic [31:0] act;
        n_checks++;
        if (sbq.size() == 0) begin
            $display("FAIL scoreboard_empty: got no expectation, want one (dut%0d)", d);
            return;
        end
        it = sbq.pop_front();
        if (is_rd != (it.sel == 0) || (is_rd && it.d != d)) begin
            $display("FAIL %s: got unexpected transaction kind, want sel %0d", it.name, it.sel);
            return;
        end
        act = actual(it);
        if (act === it.exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h", it.name, act, it.exp);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) if (cs[d] && wn[d]) pop_cmp(1'b1, d);
        for (int i = 0; i < obs_n; i++) pop_cmp(1'b0, -1);
    end

    // Driver
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cs[d] = 1'b0;
            wn[d] = 1'b1;
        end
        obs_n = 0;
    endtask

    task automatic wr(int d, logic [2:0] a, logic [31:0] v);
        cs[d] = 1'b1; wn[d] = 1'b0; adr[d] = a; wd[d] = v;
        step();
    endtask

    task automatic rd_chk(int d, logic [2:0] a, logic [31:0] e, string nm);
        cs[d] = 1'b1; wn[d] = 1'b1; adr[d] = a;
        sbq.push_back('{d, 0, e, nm});
    endtask

    task automatic obs_chk(int d, int sel, logic [31:0] e, string nm);
        sbq.push_back('{d, sel, e, nm});
        obs_n++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cs[d] = 1'b0; wn[d] = 1'b1; adr[d] = '0; wd[d] = '0;
        end
        pin[0] = 32'hFFFF_FFFF;
        pin[1] = 32'h0000_00FF;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) step();

        // Reset state with pins idling high
        rd_chk(0, 3'd3, 32'h0, "rst_cap0");
        obs_chk(0, 3, 32'h0, "rst_irq0");
        obs_chk(0, 1, 32'h0, "rst_out0");
        obs_chk(0, 2, 32'h0, "rst_oe0");
        step();
        rd_chk(0, 3'd0, 32'hFFFF_FFFF, "rst_data0");
        rd_chk(1, 3'd3, 32'h0, "rst_cap1");
        obs_chk(1, 1, 32'h3C, "rst_out1");
        obs_chk(1, 2, 32'h0F, "rst_oe1");
        step();
        rd_chk(1, 3'd0, 32'hFC, "rst_data1");
        step();

        // Direction, data, atomic set/clear
        pin[0] = 32'hABCD_1234;
        wr(0, 3'd1, 32'h0000_FFFF);
        wr(0, 3'd0, 32'h1234_5678);
        wr(0, 3'd4, 32'h000F_0000);
        wr(0, 3'd5, 32'h0000_0070);
        obs_chk(0, 1, 32'h123F_5608, "setclr_out");
        step();
        rd_chk(0, 3'd0, 32'hABCD_5608, "mixed_readback");
        step();
        rd_chk(0, 3'd4, 32'h0, "outset_reads0");
        step();
        wr(0, 3'd1, 32'h0);
        obs_chk(0, 1, 32'h123F_5608, "dir_keeps_out");
        step();

        // Rising-edge latency and irq
        pin[0] = 32'h0;
        repeat (4) step();
        wr(0, 3'd3, 32'hFFFF_FFFF);
        wr(0, 3'd2, 32'h1);
        rd_chk(0, 3'd3, 32'h0, "cap_pre");
        step();
        pin[0] = 32'h1;
        step();
        obs_chk(0, 3, 32'h0, "irq_n0");
        step();
        rd_chk(0, 3'd3, 32'h0, "cap_n1");
        step();
        rd_chk(0, 3'd3, 32'h1, "cap_n2");
        obs_chk(0, 3, 32'h0, "irq_n2");
        step();
        obs_chk(0, 3, 32'h1, "irq_n3");
        step();
        wr(0, 3'd3, 32'h1);
        rd_chk(0, 3'd3, 32'h0, "cap_w1c");
        obs_chk(0, 3, 32'h1, "irq_hold_after_clr");
        step();
        obs_chk(0, 3, 32'h0, "irq_drop_after_clr");
        step();
        pin[0] = 32'h0;
        repeat (5) step();
        rd_chk(0, 3'd3, 32'h0, "no_fall_capture");
        step();

        // Set beats clear on the same bit in the same cycle
        wr(0, 3'd2, 32'h9);
        pin[0] = 32'h8;
        step();
        step();
        wr(0, 3'd3, 32'h8);
        rd_chk(0, 3'd3, 32'h8, "set_wins");
        step();
        obs_chk(0, 3, 32'h1, "irq_set_wins");
        wr(0, 3'd3, 32'h8);
        rd_chk(0, 3'd3, 32'h0, "second_clear");
        obs_chk(0, 3, 32'h1, "irq_lag");
        step();
        obs_chk(0, 3, 32'h0, "irq_dropped");
        step();

        // Narrow instance: truncation and reserved reads
        wr(1, 3'd1, 32'hFFFF_FFFF);
        wr(1, 3'd0, 32'hFFFF_FFFF);
        obs_chk(1, 1, 32'hFF, "w8_out");
        step();
        rd_chk(1, 3'd0, 32'hFF, "w8_data");
        step();
        rd_chk(1, 3'd1, 32'hFF, "w8_dir");
        step();
        for (int a = 4; a < 8; a++) begin
            rd_chk(1, 3'(a), 32'h0, "w8_reserved");
            step();
        end

        // Any-edge capture, three-stage latency
        wr(1, 3'd3, 32'hFF);
        wr(1, 3'd2, 32'h0);
        pin[1] = 32'hFE;
        step();
        step();
        step();
        rd_chk(1, 3'd3, 32'h0, "any_n2");
        step();
        rd_chk(1, 3'd3, 32'h1, "any_n3");
        step();
        wr(1, 3'd3, 32'h1);
        pin[1] = 32'hFF;
        repeat (5) step();
        rd_chk(1, 3'd3, 32'h1, "any_fall_capture");
        step();

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            int d;
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) pin[0] ^= ($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) pin[1] ^= (32'h1 << $urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: wr(d, 3'($urandom_range(0, 7)), $urandom);
                1: wr(d, 3'd3, $urandom);
                2: begin
                    logic [2:0] a;
                    a = 3'($urandom_range(0, 7));
                    rd_chk(d, a, model_read(d, a), "rand_read");
                    step();
                end
                default: begin
                    obs_chk(d, 1, m_out[d], "rand_out");
                    obs_chk(d, 2, m_dir[d], "rand_oe");
                    obs_chk(d, 3, {31'h0, m_irq[d]}, "rand_irq");
                    step();
                end
            endcase
        end

        // Asynchronous reset while irq is high
        wr(0, 3'd0, 32'hDEAD_0001);
        wr(0, 3'd2, 32'hFFFF_FFFF);
        pin[0] = 32'h0;
        repeat (6) step();
        wr(0, 3'd3, 32'hFFFF_FFFF);
        pin[0] = 32'hFFFF_FFFF;
        repeat (6) step();
        obs_chk(0, 3, 32'h1, "irq_pre_reset");
        obs_chk(0, 1, 32'hDEAD_0001, "out_pre_reset");
        step();
        reset_n = 1'b0;
        rd_chk(0, 3'd3, 32'h0, "async_cap0");
        obs_chk(0, 1, 32'h0, "async_out0");
        obs_chk(0, 2, 32'h0, "async_oe0");
        obs_chk(0, 3, 32'h0, "async_irq0");
        obs_chk(1, 1, 32'h3C, "async_out1");
        obs_chk(1, 2, 32'h0F, "async_oe1");
        obs_chk(1, 3, 32'h0, "async_irq1");
        step();
        reset_n = 1'b1;
        repeat (2) step();
        obs_chk(0, 1, 32'h0, "post_reset_out0");
        step();
        step();

        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d left, want 0", sbq.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pio_bidir_irq.md
Name: pio_bidir_irq

Overview:
Parametrised Avalon-MM slave general-purpose I/O block, successor to the output-only PIO used on the NIOSDuino soft core. It provides DATA_WIDTH bidirectional pins with a per-bit direction register and atomic set/clear of the output register. Inputs pass through a synchroniser into per-bit edge-capture flags with a maskable, level-sensitive interrupt to the Nios II. It sits on the core's data-master interconnect, one instance per Arduino header port group.

Parameters:
DATA_WIDTH, 32, number of I/O bits (1..32); writedata/readdata bits above DATA_WIDTH are ignored on write and read as 0
OUT_RESET, 0, reset value of the output data register
DIR_RESET, 0, reset value of the direction register (1 = output)
EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any
SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero wait states, combinational from address
in_port  in  DATA_WIDTH  pad input values
out_port  out  DATA_WIDTH  output data register
oe_port  out  DATA_WIDTH  per-bit output enable (= direction register)
irq  out  1  interrupt request, active high

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low; all registers clear on assertion, mid-operation included.
- Write strobe: wr = chipselect & ~write_n. Registers update on the next rising clk edge.
- Reset values: out_port=OUT_RESET, oe_port=DIR_RESET, irq_mask=0, edge_capture=0, irq=0, synchroniser and previous-value registers 0.
- Register map (address):
  - 0 DATA. Write loads data_out. Read returns (dir & data_out) | (~dir & in_sync).
  - 1 DIRECTION. R/W.
  - 2 IRQMASK. R/W.
  - 3 EDGECAPTURE. Read returns flags; write is write-1-to-clear.
  - 4 OUTSET. Write: data_out |= wdata. Reads 0.
  - 5 OUTCLEAR. Write: data_out &= ~wdata. Reads 0.
  - 6, 7 reserved. Reads 0; writes ignored.
- Synchroniser: in_port passes through a SYNC_STAGES-deep flop chain to give in_sync. A further register holds prev = in_sync delayed by one cycle.
- Edge detection:
  - rising = in_sync & ~prev; falling = ~in_sync & prev; any = in_sync ^ prev; selected by EDGE_TYPE.
  - Latency: a pin change first sampled at edge 0 sets its capture bit at edge SYNC_STAGES.
- Arm window: a small counter suppresses edge detection for the first SYNC_STAGES+1 cycles after reset deassertion. This prevents spurious captures from the zero-initialised chain when pins idle high.
- Capture update, per bit, each cycle: capture_next = (capture & ~clr) | det, where clr = wdata when wr to address 3.
  - A simultaneous detect and clear on the same bit: set wins, so no event is lost.
  - Flags are sticky until cleared.
- IRQ: irq = |(edge_capture & irq_mask), registered. It rises one cycle after the capture bit is set or the mask bit is written. It falls one cycle after the clear or unmask.
- Direction: a direction change affects only readback and oe_port. data_out is retained.

Test Plan:
- Reset with in_port=all-ones, DIR_RESET=0 -> after SYNC_STAGES+5 cycles edge_capture=0, irq=0, DATA read 0xFFFFFFFF, out_port=0, oe_port=0.
- Write DIRECTION=0x0000FFFF, DATA=0x12345678, then OUTSET 0x000F0000 and OUTCLEAR 0x00000070 -> out_port=0x123F5608; DATA read = in_port[31:16] concatenated with 0x5608.
- EDGE_TYPE=0, SYNC_STAGES=2, IRQMASK=0x1: raise in_port[0] sampled at edge N -> capture[0]=1 at edge N+2, irq=1 at N+3; falling edge produces no capture.
- In the same cycle in_port[3] produces an edge and a write to address 3 with 0x8 -> capture[3] stays 1; a second clear write -> 0, irq drops next cycle.
- DATA_WIDTH=8: write DATA 0xFFFFFFFF with DIRECTION 0xFF -> out_port=0xFF, DATA readdata=0x000000FF; reads of addresses 4..7 return 0.
- Assert reset_n mid-sequence with irq=1 and out_port non-zero -> all outputs return to reset values immediately, without waiting for a clk edge.
